// File: rtl/fp_to_fixed_conv.sv
// IEEE-754 single -> 22-bit signed fixed point (FRAC_BITS fractional) for the CORDIC datapath.
// Latency 3, throughput 1/cycle; whole pipeline stalls on out_valid && !out_ready. Option: FP2FIX_ROUND_EN.
module fp_to_fixed_conv #(
    parameter int FRAC_BITS = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [21:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ovf,
    output logic        out_nan
);

    // Exponents at or above this shift the mantissa past 2^22 output LSBs: saturation is certain.
    localparam logic [7:0] BIG_EXP = 8'(149 - FRAC_BITS);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1: unpack
    logic        s1_vld, s1_sign, s1_zero, s1_inf, s1_nan;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
        end else if (adv) begin
            s1_vld  <= in_valid;
            s1_sign <= in_data[31];
            s1_exp  <= in_data[30:23];
            s1_mant <= {|in_data[30:23], in_data[22:0]};
            s1_zero <= (in_data[30:23] == 8'd0);
            s1_inf  <= (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
            s1_nan  <= (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
        end
    end

    // S2: magnitude in half-LSB units so the rounding bit survives the shift
    logic        s2_vld, s2_sign, s2_zero, s2_inf, s2_nan, s2_big;
    logic [23:0] s2_mag_half;
    logic [8:0]  rshift;
    logic        big_d;

    always_comb begin
        big_d  = (s1_exp >= BIG_EXP);
        rshift = {1'b0, BIG_EXP} - {1'b0, s1_exp};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld <= 1'b0;
        end else if (adv) begin
            s2_vld      <= s1_vld;
            s2_sign     <= s1_sign;
            s2_zero     <= s1_zero;
            s2_inf      <= s1_inf;
            s2_nan      <= s1_nan;
            s2_big      <= big_d;
            s2_mag_half <= big_d ? 24'd0 : (s1_mant >> rshift);
        end
    end

    // S3: round/truncate, saturate, apply sign
    logic [23:0] mag, neg_mag;
    logic        sat_pos, sat_neg;
    logic [21:0] res_data;
    logic        res_ovf, res_nan;

    always_comb begin
`ifdef FP2FIX_ROUND_EN
        mag = (s2_mag_half + 24'd1) >> 1;
`else
        mag = {1'b0, s2_mag_half[23:1]};
`endif
        neg_mag  = 24'd0 - mag;
        sat_pos  = s2_big || (mag >= 24'h200000);
        sat_neg  = s2_big || (mag >  24'h200000);
        res_data = 22'd0;
        res_ovf  = 1'b0;
        res_nan  = 1'b0;
        if (s2_nan) begin
            res_nan = 1'b1;
        end else if (s2_zero) begin
            res_data = 22'd0;
        end else if (s2_inf || (s2_sign ? sat_neg : sat_pos)) begin
            res_data = s2_sign ? 22'h200000 : 22'h1FFFFF;
            res_ovf  = 1'b1;
        end else begin
            res_data = s2_sign ? neg_mag[21:0] : mag[21:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 22'd0;
            out_ovf   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_vld;
            out_data  <= res_data;
            out_ovf   <= res_ovf;
            out_nan   <= res_nan;
        end
    end

endmodule

// File: doc/fp_to_fixed_conv.md
FP_TO_FIXED_CONV -- requirements
Module: fp_to_fixed_conv

Interface
REQ-001 SHALL provide parameter: FRAC_BITS, 14, number of fractional bits in the 22-bit signed fixed-point output (integer range [-2^(21-FRAC_BITS), 2^(21-FRAC_BITS))).
REQ-002 SHALL provide port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: in_data  input  32  IEEE-754 single-precision operand.
REQ-005 SHALL provide port: in_valid  input  1  in_data valid this cycle.
REQ-006 SHALL provide port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL provide port: out_data  output  22  two's-complement fixed-point result feeding the 22-bit CORDIC datapath.
REQ-008 SHALL provide port: out_valid  output  1  out_data valid.
REQ-009 SHALL provide port: out_ready  input  1  downstream CORDIC stage accepts out_data.
REQ-010 SHALL provide port: out_ovf  output  1  result saturated (overflow or infinity), qualified by out_valid.
REQ-011 SHALL provide port: out_nan  output  1  input was NaN, qualified by out_valid.

Function
REQ-012 SHALL implement a 3-stage pipeline: S1 unpack (sign, exponent, mantissa with hidden bit, class), S2 barrel shift of magnitude by (exp-127+FRAC_BITS-23), S3 rounding/saturation/negation into output register.
REQ-013 SHALL transfer on input when in_valid and in_ready are both 1; output transfer when out_valid and out_ready are both 1.
REQ-014 SHALL advance the whole pipeline when adv = !out_valid || out_ready; otherwise all stages hold, including their contents.
REQ-015 SHALL drive in_ready = adv combinationally; in_ready SHALL NOT depend on in_valid.
REQ-016 SHALL present a result accepted in cycle N on out_data/out_valid in cycle N+3 when adv is 1 throughout (latency 3, throughput 1/cycle).
REQ-017 SHALL propagate bubbles: a stage whose predecessor held no valid item becomes invalid on advance.
REQ-018 SHALL, with ROUND disabled, truncate magnitude toward zero before applying sign.
REQ-019 SHALL map zero and denormals (exp=0) to out_data=0, ovf=0, nan=0; negative results that truncate to 0 SHALL yield 0 (no -0).
REQ-020 SHALL saturate when magnitude >= 2^(21-FRAC_BITS) (positive) or > 2^(21-FRAC_BITS) (negative): out_data=0x1FFFFF or 0x200000, out_ovf=1; exactly -2^(21-FRAC_BITS) SHALL yield 0x200000 with out_ovf=0.
REQ-021 SHALL treat infinity (exp=255, mantissa=0) as saturation per sign with out_ovf=1.
REQ-022 SHALL map NaN (exp=255, mantissa!=0) to out_data=0, out_nan=1, out_ovf=0.
REQ-023 SHALL hold out_data, out_ovf, out_nan stable while out_valid=1 and out_ready=0.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, clear all stage valid bits, out_valid=0, out_data=0, out_ovf=0, out_nan=0.
REQ-025 SHALL discard all in-flight items on reset mid-operation; no item accepted before reset appears after it.
REQ-026 SHALL hold in_ready=1 during and after reset (pipeline empty).

Configuration
REQ-027 SHALL compile round-half-away-from-zero when FP2FIX_ROUND_EN is defined: add half output LSB to magnitude before final truncation, re-checking saturation after the add.
REQ-028 SHALL, without FP2FIX_ROUND_EN, use truncation per REQ-018 and contain no rounding adder.

Verification
REQ-029 SHALL verify: in_data=0x41200000 (10.0), out_ready=1 -> out_data=0x028000 exactly 3 cycles after acceptance, ovf=0, nan=0.
REQ-030 SHALL verify: 0xBFC00000 (-1.5) -> out_data=0x3FA000; 0x43480000 (200.0) -> 0x1FFFFF, out_ovf=1; 0xC3000000 (-128.0) -> 0x200000, out_ovf=0.
REQ-031 SHALL verify: 0x7FC00000 -> out_data=0, out_nan=1; 0xFF800000 -> 0x200000, out_ovf=1; 0x00000001 -> 0.
REQ-032 SHALL verify backpressure: out_ready=0, in_valid=1 continuously -> exactly 3 items accepted, then in_ready=0; raising out_ready drains items in order, no loss or duplication.
REQ-033 SHALL verify rounding: 0x38000000 (2^-15) -> out_data=0 without FP2FIX_ROUND_EN, 0x000001 with it.
REQ-034 SHALL verify reset asserted with 3 items in flight -> out_valid=0 next cycle, in_ready=1, no stale output afterwards.
